// File: rtl/prio_onehot_decoder.sv
// Decodes {code, z} words into a one-hot strobe held for HOLD_CYCLES, followed by GAP_CYCLES idle cycles.
// Define PRIO_DEC_SEEN_EN to add the clr_seen/seen sticky record of accepted channels.
module prio_onehot_decoder #(
  parameter int HOLD_CYCLES = 4,
  parameter int GAP_CYCLES  = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [2:0] code,
  input  logic       z,
  output logic [7:0] onehot,
  output logic       busy,
  output logic       done
`ifdef PRIO_DEC_SEEN_EN
  ,
  input  logic       clr_seen,
  output logic [7:0] seen
`endif
);

  typedef enum logic [1:0] {IDLE, HOLD, GAP} state_t;

  localparam logic [7:0] HOLD_INIT = 8'(HOLD_CYCLES - 1);
  localparam logic [7:0] GAP_INIT  = 8'(GAP_CYCLES - 1);

  state_t     state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  logic [7:0] onehot_q, onehot_d;
  logic       done_q, done_d;
  logic       accept;

  assign in_ready = (state_q == IDLE) && rst_n;
  assign accept   = in_valid && in_ready;
  assign onehot   = onehot_q;
  assign done     = done_q;
  assign busy     = (state_q != IDLE);

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    onehot_d = onehot_q;
    done_d   = 1'b0;
    case (state_q)
      IDLE: begin
        onehot_d = '0;
        if (accept) begin
          if (z) begin
            done_d = 1'b1;
          end else begin
            onehot_d = 8'b1 << code;
            state_d  = HOLD;
            cnt_d    = HOLD_INIT;
          end
        end
      end
      HOLD: begin
        if (cnt_q == '0) begin
          onehot_d = '0;
          done_d   = 1'b1;
          if (GAP_CYCLES > 0) begin
            state_d = GAP;
            cnt_d   = GAP_INIT;
          end else begin
            state_d = IDLE;
          end
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      GAP: begin
        onehot_d = '0;
        if (cnt_q == '0) state_d = IDLE;
        else             cnt_d   = cnt_q - 8'd1;
      end
      default: begin
        state_d  = IDLE;
        cnt_d    = '0;
        onehot_d = '0;
      end
    endcase
  end

`ifdef PRIO_DEC_SEEN_EN
  logic [7:0] seen_q, seen_d;
  assign seen = seen_q;

  // A clear coinciding with an accept keeps only the newly accepted channel.
  always_comb begin
    seen_d = clr_seen ? '0 : seen_q;
    if (accept && !z) seen_d = seen_d | (8'b1 << code);
  end
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      onehot_q <= '0;
      done_q   <= 1'b0;
`ifdef PRIO_DEC_SEEN_EN
      seen_q   <= '0;
`endif
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      onehot_q <= onehot_d;
      done_q   <= done_d;
`ifdef PRIO_DEC_SEEN_EN
      seen_q   <= seen_d;
`endif
    end
  end

endmodule

// File: tb/tb_prio_onehot_decoder.sv
// Bench for prio_onehot_decoder: default instance plus a HOLD=1/GAP=0 instance, checked against a timing model.
module tb_prio_onehot_decoder;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [1:0] vld, zz, rdy, bsy, dn, last_acc;
  logic [2:0] cd [2];
  logic [7:0] oh [2];
  int         n_cmp = 0;
  int         n_bad = 0;
  int         cyc = 0;
  int         acc_e [2];
  int         zacc_e [2];
  logic [2:0] acc_c [2];
`ifdef PRIO_DEC_SEEN_EN
  logic [1:0] clr;
  logic [7:0] sn [2];
  logic [7:0] seen_m [2];
`endif

  always #5 clk = ~clk;

  prio_onehot_decoder dut0 (
    .clk(clk), .rst_n(rst_n), .in_valid(vld[0]), .in_ready(rdy[0]), .code(cd[0]), .z(zz[0]),
    .onehot(oh[0]), .busy(bsy[0]), .done(dn[0])
`ifdef PRIO_DEC_SEEN_EN
    , .clr_seen(clr[0]), .seen(sn[0])
`endif
  );

  prio_onehot_decoder #(.HOLD_CYCLES(1), .GAP_CYCLES(0)) dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(vld[1]), .in_ready(rdy[1]), .code(cd[1]), .z(zz[1]),
    .onehot(oh[1]), .busy(bsy[1]), .done(dn[1])
`ifdef PRIO_DEC_SEEN_EN
    , .clr_seen(clr[1]), .seen(sn[1])
`endif
  );

  // Model: outputs follow from the distance (in cycles) to the most recent accept.
  function automatic int hold_of(int i); return (i == 0) ? 4 : 1; endfunction
  function automatic int gap_of(int i);  return (i == 0) ? 1 : 0; endfunction

  function automatic logic m_busy(int i);
    int d = cyc - acc_e[i];
    return (d >= 0) && (d < hold_of(i) + gap_of(i));
  endfunction

  function automatic logic [7:0] m_onehot(int i);
    int d = cyc - acc_e[i];
    if (d >= 0 && d < hold_of(i)) return 8'd1 << acc_c[i];
    return 8'd0;
  endfunction

  function automatic logic m_done(int i);
    return (cyc - acc_e[i] == hold_of(i)) || (cyc == zacc_e[i]);
  endfunction

  function automatic logic m_ready(int i);
    return !m_busy(i) && rst_n;
  endfunction

  task automatic tick();
    logic [1:0] acc;
    for (int i = 0; i < 2; i++) acc[i] = vld[i] && rst_n && !m_busy(i);
    @(posedge clk);
    cyc++;
    for (int i = 0; i < 2; i++) begin
      last_acc[i] = acc[i];
      if (!rst_n) begin
        acc_e[i]  = -1000;
        zacc_e[i] = -1000;
`ifdef PRIO_DEC_SEEN_EN
        seen_m[i] = 8'd0;
`endif
      end else begin
`ifdef PRIO_DEC_SEEN_EN
        if (clr[i]) seen_m[i] = 8'd0;
        if (acc[i] && !zz[i]) seen_m[i] = seen_m[i] | (8'd1 << cd[i]);
`endif
        if (acc[i]) begin
          if (zz[i]) zacc_e[i] = cyc;
          else begin
            acc_e[i] = cyc;
            acc_c[i] = cd[i];
          end
        end
      end
    end
    #1;
  endtask

  task automatic wait_accept(input int i, input int budget);
    int n = 0;
    do begin
      tick();
      n++;
    end while (!last_acc[i] && n < budget);
    n_cmp++;
    if (!last_acc[i]) begin
      n_bad++;
      $display("FAIL accept_timeout inst%0d: no accept within %0d cycles", i, budget);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    vld = '0; zz = '0; cd[0] = '0; cd[1] = '0;
`ifdef PRIO_DEC_SEEN_EN
    clr = '0;
`endif
    tick();
    tick();
    for (int i = 0; i < 2; i++) begin
      n_cmp++; if (oh[i] !== 8'h00) begin n_bad++; $display("FAIL reset_onehot inst%0d: got %h want 00", i, oh[i]); end
      n_cmp++; if (bsy[i] !== 1'b0) begin n_bad++; $display("FAIL reset_busy inst%0d: got %b want 0", i, bsy[i]); end
      n_cmp++; if (dn[i] !== 1'b0) begin n_bad++; $display("FAIL reset_done inst%0d: got %b want 0", i, dn[i]); end
      n_cmp++; if (rdy[i] !== 1'b0) begin n_bad++; $display("FAIL reset_ready_low inst%0d: got %b want 0", i, rdy[i]); end
`ifdef PRIO_DEC_SEEN_EN
      n_cmp++; if (sn[i] !== 8'h00) begin n_bad++; $display("FAIL reset_seen inst%0d: got %h want 00", i, sn[i]); end
`endif
    end
    rst_n = 1'b1;
    #1;
    for (int i = 0; i < 2; i++) begin
      n_cmp++; if (rdy[i] !== 1'b1) begin n_bad++; $display("FAIL reset_ready inst%0d: got %b want 1", i, rdy[i]); end
    end
  endtask

  task automatic test_single();
    cd[0] = 3'b110; zz[0] = 1'b0; vld[0] = 1'b1;
    tick();
    vld[0] = 1'b0;
    n_cmp++; if (last_acc[0] !== 1'b1) begin n_bad++; $display("FAIL single_accept: got %b want 1", last_acc[0]); end
    for (int k = 0; k < 7; k++) begin
      n_cmp++;
      if (oh[0] !== ((k <= 3) ? 8'h40 : 8'h00)) begin
        n_bad++; $display("FAIL single_onehot k=%0d: got %h want %h", k, oh[0], (k <= 3) ? 8'h40 : 8'h00);
      end
      n_cmp++;
      if (dn[0] !== (k == 4)) begin n_bad++; $display("FAIL single_done k=%0d: got %b want %b", k, dn[0], k == 4); end
      n_cmp++;
      if (rdy[0] !== (k >= 5)) begin n_bad++; $display("FAIL single_ready k=%0d: got %b want %b", k, rdy[0], k >= 5); end
      tick();
    end
  endtask

  task automatic test_back_to_back();
    int prev = 0;
    vld[0] = 1'b1; zz[0] = 1'b0;
    for (int c = 0; c < 8; c++) begin
      int n = 0;
      cd[0] = 3'(c);
      do begin
        tick();
        n++;
        n_cmp++;
        if (oh[0] !== m_onehot(0) || $countones(oh[0]) > 1) begin
          n_bad++; $display("FAIL sweep_onehot code=%0d: got %h want %h", c, oh[0], m_onehot(0));
        end
      end while (!last_acc[0] && n < 20);
      n_cmp++;
      if (!last_acc[0]) begin
        n_bad++; $display("FAIL sweep_timeout code=%0d: got no accept want accept", c);
      end else begin
        n_cmp++;
        if (oh[0] !== (8'd1 << c)) begin n_bad++; $display("FAIL sweep_value code=%0d: got %h want %h", c, oh[0], 8'd1 << c); end
        if (c > 0) begin
          n_cmp++;
          if (cyc - prev != 6) begin n_bad++; $display("FAIL sweep_period code=%0d: got %0d want 6", c, cyc - prev); end
        end
        prev = cyc;
      end
    end
    vld[0] = 1'b0;
    for (int k = 0; k < 8; k++) tick();
  endtask

  task automatic test_z_request();
    cd[0] = 3'b101; zz[0] = 1'b1; vld[0] = 1'b1;
    tick();
    vld[0] = 1'b0; zz[0] = 1'b0;
    n_cmp++; if (oh[0] !== 8'h00) begin n_bad++; $display("FAIL z_onehot: got %h want 00", oh[0]); end
    n_cmp++; if (dn[0] !== 1'b1) begin n_bad++; $display("FAIL z_done: got %b want 1", dn[0]); end
    n_cmp++; if (rdy[0] !== 1'b1) begin n_bad++; $display("FAIL z_ready: got %b want 1", rdy[0]); end
    n_cmp++; if (bsy[0] !== 1'b0) begin n_bad++; $display("FAIL z_busy: got %b want 0", bsy[0]); end
    tick();
    n_cmp++; if (dn[0] !== 1'b0) begin n_bad++; $display("FAIL z_done_end: got %b want 0", dn[0]); end
  endtask

  task automatic test_reset_mid_hold();
    cd[0] = 3'd3; zz[0] = 1'b0; vld[0] = 1'b1;
    tick();
    vld[0] = 1'b0;
    tick();
    n_cmp++; if (oh[0] !== 8'h08) begin n_bad++; $display("FAIL midrst_pre: got %h want 08", oh[0]); end
    rst_n = 1'b0;
    tick();
    n_cmp++; if (oh[0] !== 8'h00) begin n_bad++; $display("FAIL midrst_onehot: got %h want 00", oh[0]); end
    n_cmp++; if (bsy[0] !== 1'b0) begin n_bad++; $display("FAIL midrst_busy: got %b want 0", bsy[0]); end
    rst_n = 1'b1;
    for (int k = 0; k < 6; k++) begin
      n_cmp++; if (dn[0] !== 1'b0) begin n_bad++; $display("FAIL midrst_done k=%0d: got %b want 0", k, dn[0]); end
      tick();
    end
  endtask

  task automatic test_fast_period();
    int prev = 0;
    int acc_n = 0;
    int n = 0;
    cd[1] = 3'd0; zz[1] = 1'b0; vld[1] = 1'b1;
    while (acc_n < 4 && n < 30) begin
      tick();
      n++;
      if (last_acc[1]) begin
        acc_n++;
        n_cmp++; if (oh[1] !== 8'h01) begin n_bad++; $display("FAIL fast_onehot: got %h want 01", oh[1]); end
        if (acc_n > 1) begin
          n_cmp++; if (cyc - prev != 2) begin n_bad++; $display("FAIL fast_period: got %0d want 2", cyc - prev); end
        end
        prev = cyc;
      end else if (acc_n > 0) begin
        n_cmp++;
        if (oh[1] !== 8'h00 || dn[1] !== 1'b1) begin
          n_bad++; $display("FAIL fast_gap: got onehot=%h done=%b want 00/1", oh[1], dn[1]);
        end
      end
    end
    n_cmp++; if (acc_n != 4) begin n_bad++; $display("FAIL fast_timeout: got %0d accepts want 4", acc_n); end
    vld[1] = 1'b0;
    tick();
  endtask

`ifdef PRIO_DEC_SEEN_EN
  task automatic test_seen();
    clr[1] = 1'b1;
    tick();
    clr[1] = 1'b0;
    n_cmp++; if (sn[1] !== 8'h00) begin n_bad++; $display("FAIL seen_clear: got %h want 00", sn[1]); end
    zz[1] = 1'b0; vld[1] = 1'b1; cd[1] = 3'd2;
    wait_accept(1, 10);
    cd[1] = 3'd5;
    wait_accept(1, 10);
    vld[1] = 1'b0;
    tick();
    n_cmp++; if (sn[1] !== 8'h24) begin n_bad++; $display("FAIL seen_sticky: got %h want 24", sn[1]); end
    clr[1] = 1'b1; cd[1] = 3'd7; vld[1] = 1'b1;
    tick();
    clr[1] = 1'b0; vld[1] = 1'b0;
    n_cmp++; if (last_acc[1] !== 1'b1) begin n_bad++; $display("FAIL seen_clr_accept: got %b want 1", last_acc[1]); end
    n_cmp++; if (sn[1] !== 8'h80) begin n_bad++; $display("FAIL seen_clr_with_accept: got %h want 80", sn[1]); end
    tick();
  endtask
`endif

  task automatic test_random();
    for (int t = 0; t < 500; t++) begin
      rst_n = ($urandom_range(0, 59) != 0);
      for (int i = 0; i < 2; i++) begin
        if (!vld[i] || last_acc[i]) begin
          vld[i] = ($urandom_range(0, 2) != 0);
          cd[i]  = 3'($urandom_range(0, 7));
          zz[i]  = ($urandom_range(0, 5) == 0);
        end
`ifdef PRIO_DEC_SEEN_EN
        clr[i] = ($urandom_range(0, 9) == 0);
`endif
      end
      tick();
      for (int i = 0; i < 2; i++) begin
        n_cmp++;
        if (oh[i] !== m_onehot(i) || $countones(oh[i]) > 1) begin
          n_bad++; $display("FAIL rand_onehot inst%0d t=%0d: got %h want %h", i, t, oh[i], m_onehot(i));
        end
        n_cmp++;
        if (bsy[i] !== m_busy(i)) begin n_bad++; $display("FAIL rand_busy inst%0d t=%0d: got %b want %b", i, t, bsy[i], m_busy(i)); end
        n_cmp++;
        if (dn[i] !== m_done(i)) begin n_bad++; $display("FAIL rand_done inst%0d t=%0d: got %b want %b", i, t, dn[i], m_done(i)); end
        n_cmp++;
        if (rdy[i] !== m_ready(i)) begin n_bad++; $display("FAIL rand_ready inst%0d t=%0d: got %b want %b", i, t, rdy[i], m_ready(i)); end
`ifdef PRIO_DEC_SEEN_EN
        n_cmp++;
        if (sn[i] !== seen_m[i]) begin n_bad++; $display("FAIL rand_seen inst%0d t=%0d: got %h want %h", i, t, sn[i], seen_m[i]); end
`endif
      end
    end
    vld = '0;
`ifdef PRIO_DEC_SEEN_EN
    clr = '0;
`endif
    rst_n = 1'b1;
    tick();
  endtask

  initial begin
    last_acc = '0;
    for (int i = 0; i < 2; i++) begin
      acc_e[i] = -1000; zacc_e[i] = -1000; acc_c[i] = '0;
`ifdef PRIO_DEC_SEEN_EN
      seen_m[i] = 8'd0;
`endif
    end
    test_reset();
    test_single();
    test_back_to_back();
    test_z_request();
    test_reset_mid_hold();
    test_fast_period();
`ifdef PRIO_DEC_SEEN_EN
    test_seen();
`endif
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog expired");
  end

endmodule
